// File: rtl/dir_input_pkg.sv
// Shared constants, FSM state type and helpers for the direction-word writer.
package dir_input_pkg;

  localparam int NUM_DIRS          = 4;
  localparam int DIR_UP            = 0;
  localparam int DIR_DOWN          = 1;
  localparam int DIR_RIGHT         = 2;
  localparam int DIR_LEFT          = 3;
  localparam int DEFAULT_BASE_ADDR = 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WRITE
  } wr_state_e;

  // Lowest set bit wins so multiple pending directions are served up, down, right, left.
  function automatic logic [1:0] lowest_set(input logic [NUM_DIRS-1:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = NUM_DIRS - 1; i >= 0; i--) begin
      if (v[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Each bit replaced by the level of the opposing direction in its pair.
  function automatic logic [NUM_DIRS-1:0] opposite(input logic [NUM_DIRS-1:0] s);
    logic [NUM_DIRS-1:0] o;
    o[DIR_UP]    = s[DIR_DOWN];
    o[DIR_DOWN]  = s[DIR_UP];
    o[DIR_RIGHT] = s[DIR_LEFT];
    o[DIR_LEFT]  = s[DIR_RIGHT];
    return o;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button: 2-flop synchroniser, stability counter, accepted level and a
// combinational toggle flag that is high in the cycle before the level flips.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic stable,
  output logic toggle
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  // The count would hit DEBOUNCE_CYCLES on this edge: flip the level and restart.
  always_comb begin
    cnt_next = '0;
    toggle   = 1'b0;
    if (sync2_reg != stable_reg) begin
      if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
        toggle = 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg  <= btn_raw;
      sync2_reg  <= sync1_reg;
      stable_reg <= stable_reg ^ toggle;
      cnt_reg    <= cnt_next;
    end
  end

  assign stable = stable_reg;

endmodule

// File: rtl/dir_input_writer.sv
// Debounces four direction buttons and writes each changed level to game RAM
// through a req/gnt arbiter. Optional macro DIR_LOCKOUT_EN suppresses opposing pairs.
module dir_input_writer
  import dir_input_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 12,
  parameter int BASE_ADDR       = DEFAULT_BASE_ADDR,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_DIRS-1:0]      btn_raw,
  output logic                     wr_req,
  input  logic                     wr_gnt,
  output logic                     wEn,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0]    dataIn,
  output logic [NUM_DIRS-1:0]      dir_state
);

  logic [NUM_DIRS-1:0]      stable_vec;
  logic [NUM_DIRS-1:0]      toggle_vec;
  logic [NUM_DIRS-1:0]      stable_next;
  logic [NUM_DIRS-1:0]      report_next;
  logic [NUM_DIRS-1:0]      change;

  wr_state_e                state_reg, state_next;
  logic [1:0]               idx_reg, idx_next;
  logic [NUM_DIRS-1:0]      pending_reg, pending_next;
  logic [NUM_DIRS-1:0]      dir_state_reg;
  logic                     wr_req_reg, wr_req_next;
  logic                     wen_reg, wen_next;
  logic [ADDRESS_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]    data_reg, data_next;

  generate
    for (genvar gi = 0; gi < NUM_DIRS; gi++) begin : g_db
      debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_raw[gi]),
        .stable (stable_vec[gi]),
        .toggle (toggle_vec[gi])
      );
    end
  endgenerate

  // Look one edge ahead so a change is flagged on the same edge the level flips.
  assign stable_next = stable_vec ^ toggle_vec;
`ifdef DIR_LOCKOUT_EN
  assign report_next = stable_next & ~opposite(stable_next);
`else
  assign report_next = stable_next;
`endif
  assign change = dir_state_reg ^ report_next;

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    pending_next = pending_reg | change;
    wr_req_next  = wr_req_reg;
    wen_next     = 1'b0;
    addr_next    = addr_reg;
    data_next    = data_reg;
    case (state_reg)
      IDLE: begin
        wr_req_next = 1'b0;
        if (pending_reg != '0) begin
          idx_next    = lowest_set(pending_reg);
          wr_req_next = 1'b1;
          state_next  = REQ;
        end
      end
      REQ: begin
        wr_req_next = 1'b1;
        if (wr_gnt) begin
          state_next = WRITE;
          wen_next   = 1'b1;
          addr_next  = ADDRESS_WIDTH'(BASE_ADDR) + ADDRESS_WIDTH'(idx_reg);
          // Latest level, including a flip landing on this very edge.
          data_next  = DATA_WIDTH'(report_next[idx_reg]);
        end
      end
      WRITE: begin
        wr_req_next  = 1'b0;
        // A fresh change on the served bit re-sets it: set beats clear.
        pending_next = (pending_reg & ~(NUM_DIRS'(1) << idx_reg)) | change;
        state_next   = IDLE;
      end
      default: begin
        state_next  = IDLE;
        wr_req_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= 2'd0;
      pending_reg   <= '0;
      dir_state_reg <= '0;
      wr_req_reg    <= 1'b0;
      wen_reg       <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      pending_reg   <= pending_next;
      dir_state_reg <= report_next;
      wr_req_reg    <= wr_req_next;
      wen_reg       <= wen_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
    end
  end

  assign wr_req    = wr_req_reg;
  assign wEn       = wen_reg;
  assign addr      = addr_reg;
  assign dataIn    = data_reg;
  assign dir_state = dir_state_reg;

endmodule
